// File: rtl/stream_mux_arbiter_pkg.sv
// Shared definitions for the stream multiplexer/arbiter: mode encodings
// and the packet-lock FSM state type.
package stream_mux_arbiter_pkg;

  localparam logic MUX_MODE_SEL = 1'b0;
  localparam logic MUX_MODE_RR  = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } mux_state_t;

endpackage

// File: rtl/stream_mux_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first requesting
// channel found scanning ptr_i, ptr_i+1, ... modulo CHANNELS.
module rr_arbiter
  import stream_mux_arbiter_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int SEL_BITS = 3
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [SEL_BITS-1:0] ptr_i,
  output logic                grant_valid_o,
  output logic [SEL_BITS-1:0] grant_idx_o
);

  logic [2*CHANNELS-1:0] req2;
  logic [2*CHANNELS-1:0] rot;
  int                    pos;

  // Rotate the request vector so the pointer lands at bit 0, then pick the
  // lowest set bit; scanning downward lets the nearest request win last.
  always_comb begin
    grant_valid_o = 1'b0;
    grant_idx_o   = '0;
    pos           = 0;
    req2          = {req_i, req_i};
    rot           = req2 >> ptr_i;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        grant_valid_o = 1'b1;
        pos           = int'(ptr_i) + i;
        if (pos >= CHANNELS) pos = pos - CHANNELS;
        grant_idx_o   = SEL_BITS'(pos);
      end
    end
  end

endmodule

// File: rtl/stream_mux_arbiter.sv
// N-channel valid/ready stream multiplexer with explicit-select or
// round-robin arbitration, packet-level grant locking and one output
// register stage running at full throughput.
module stream_mux_arbiter
  import stream_mux_arbiter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 8,
  parameter int SEL_BITS = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_BITS-1:0]       sel,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic [SEL_BITS-1:0]       out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  mux_state_t          state_q, state_d;
  logic [SEL_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_BITS-1:0] lock_chan_q, lock_chan_d;

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [SEL_BITS-1:0] out_chan_q, out_chan_d;

  logic                rr_gv;
  logic [SEL_BITS-1:0] rr_gi;
  logic                sel_req;
  logic                grant_vld;
  logic [SEL_BITS-1:0] grant_idx;
  logic                gnt_in_valid;
  logic                gnt_last;
  logic [WIDTH-1:0]    gnt_data;
  logic                load_en;
  logic                xfer;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_BITS (SEL_BITS)
  ) u_rr (
    .req_i         (in_valid),
    .ptr_i         (rr_ptr_q),
    .grant_valid_o (rr_gv),
    .grant_idx_o   (rr_gi)
  );

  // Output register can take a beat when empty or being drained this cycle.
  assign load_en = !out_valid_q || out_ready;

  // Choose the granted channel: the lock holder while mid-packet, otherwise
  // the round-robin winner or the explicitly selected channel.
  always_comb begin
    sel_req = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_BITS'(i)) sel_req = in_valid[i];
    end
    grant_vld = 1'b0;
    grant_idx = '0;
    if (state_q == ST_LOCKED) begin
      grant_vld = 1'b1;
      grant_idx = lock_chan_q;
    end else if (mode == MUX_MODE_RR) begin
      grant_vld = rr_gv;
      grant_idx = rr_gi;
    end else begin
      grant_vld = sel_req;
      grant_idx = sel;
    end
  end

  // Mux the granted channel's payload and drive its ready; ready is held
  // low while reset is asserted so nothing is consumed that cycle.
  always_comb begin
    gnt_in_valid = 1'b0;
    gnt_last     = 1'b0;
    gnt_data     = '0;
    in_ready     = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SEL_BITS'(i)) begin
        gnt_in_valid = in_valid[i];
        gnt_last     = in_last[i];
        gnt_data     = in_data[i*WIDTH +: WIDTH];
        in_ready[i]  = grant_vld && load_en && !reset;
      end
    end
  end

  assign xfer = grant_vld && gnt_in_valid && load_en && !reset;

  // Next-state for the lock FSM, round-robin pointer and output register.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    lock_chan_d = lock_chan_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_chan_d  = out_chan_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = gnt_data;
      out_last_d  = gnt_last;
      out_chan_d  = grant_idx;
      if (gnt_last) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (grant_idx == SEL_BITS'(CHANNELS - 1)) ? '0
                                                          : grant_idx + SEL_BITS'(1);
      end else if (state_q == ST_IDLE) begin
        state_d     = ST_LOCKED;
        lock_chan_d = grant_idx;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // FSM state, arbitration pointer and lock holder.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      lock_chan_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_chan_q <= lock_chan_d;
    end
  end

  // Output register stage; an in-flight beat is dropped on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_arbiter.sv
// Directed bench for stream_mux_arbiter (8 channels x 32 bits).
module tb_stream_mux_arbiter;

  logic         clock;
  logic         reset;
  logic [255:0] in_data;
  logic [7:0]   in_valid;
  logic [7:0]   in_last;
  logic [7:0]   in_ready;
  logic         mode;
  logic [2:0]   sel;
  logic [31:0]  out_data;
  logic         out_last;
  logic [2:0]   out_chan;
  logic         out_valid;
  logic         out_ready;

  int checks;
  int passed;

  stream_mux_arbiter #(.WIDTH(32), .CHANNELS(8), .SEL_BITS(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_chan  (out_chan),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] d, input logic l);
    in_data[ch*32 +: 32] = d;
    in_last[ch] = l;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 8'hFF; mode = 1'b1; out_ready = 1'b1; sel = 3'd0;
    for (int i = 0; i < 8; i++) set_ch(i, 32'hC0DE_0000 | 32'(i), 1'b1);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
      checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data: got %h want 0", out_data); else passed++;
      checks++; if (in_ready !== 8'h00) $display("FAIL reset_in_ready: got %b want 00000000", in_ready); else passed++;
    end
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 8'h01) $display("FAIL reset_first_grant: got %b want 00000001", in_ready); else passed++;
    tick();
    checks++; if (out_chan !== 3'd0 || out_valid !== 1'b1) $display("FAIL reset_first_beat: got chan %0d valid %b want chan 0 valid 1", out_chan, out_valid); else passed++;
    in_valid = 8'h00;
    tick();
  endtask

  task automatic test_sel();
    mode = 1'b0; sel = 3'd5;
    set_ch(5, 32'hA5A5_0005, 1'b1);
    set_ch(2, 32'h2222_0002, 1'b1);
    in_valid = 8'b0010_0100;
    #1;
    checks++; if (in_ready !== 8'b0010_0000) $display("FAIL sel_in_ready: got %b want 00100000", in_ready); else passed++;
    tick();
    checks++; if (out_data !== 32'hA5A5_0005) $display("FAIL sel_data: got %h want a5a50005", out_data); else passed++;
    checks++; if (out_chan !== 3'd5 || out_valid !== 1'b1) $display("FAIL sel_chan: got chan %0d valid %b want chan 5 valid 1", out_chan, out_valid); else passed++;
    in_valid = 8'b0000_0100;
    #1;
    checks++; if (in_ready !== 8'h00) $display("FAIL sel_other_ready: got %b want 00000000", in_ready); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL sel_other_granted: got valid %b want 0", out_valid); else passed++;
  endtask

  task automatic test_rr();
    reset = 1'b1; in_valid = 8'h00; tick(); reset = 1'b0;
    mode = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) set_ch(i, 32'hC0DE_0000 | 32'(i), 1'b1);
    in_valid = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (out_chan !== 3'(k % 8) || out_valid !== 1'b1 || out_data !== (32'hC0DE_0000 | 32'(k % 8)))
        $display("FAIL rr_seq[%0d]: got chan %0d valid %b data %h want chan %0d valid 1", k, out_chan, out_valid, out_data, k % 8);
      else passed++;
    end
    in_valid = 8'b1000_0010;
    #1;
    checks++; if (in_ready !== 8'h80) $display("FAIL rr_ptr2_ready: got %b want 10000000", in_ready); else passed++;
    tick();
    checks++; if (out_chan !== 3'd7) $display("FAIL rr_ptr2_chan: got %0d want 7", out_chan); else passed++;
    checks++; if (in_ready !== 8'h02) $display("FAIL rr_wrap_ready: got %b want 00000010", in_ready); else passed++;
    tick();
    checks++; if (out_chan !== 3'd1 || out_valid !== 1'b1) $display("FAIL rr_wrap_chan: got chan %0d valid %b want chan 1 valid 1", out_chan, out_valid); else passed++;
    in_valid = 8'h00;
    tick();
  endtask

  task automatic test_lock();
    mode = 1'b1;
    set_ch(3, 32'h3000_0001, 1'b0);
    set_ch(4, 32'h4444_0004, 1'b1);
    in_valid = 8'b0001_1000;
    #1;
    checks++; if (in_ready !== 8'h08) $display("FAIL lock_first_ready: got %b want 00001000", in_ready); else passed++;
    tick();
    checks++; if (out_chan !== 3'd3 || out_data !== 32'h3000_0001 || out_last !== 1'b0) $display("FAIL lock_beat1: got chan %0d data %h last %b want chan 3 data 30000001 last 0", out_chan, out_data, out_last); else passed++;
    mode = 1'b0; sel = 3'd4;
    set_ch(3, 32'h3000_0002, 1'b0);
    #1;
    checks++; if (in_ready !== 8'h08) $display("FAIL lock_held_ready: got %b want 00001000", in_ready); else passed++;
    tick();
    checks++; if (out_chan !== 3'd3 || out_data !== 32'h3000_0002) $display("FAIL lock_beat2: got chan %0d data %h want chan 3 data 30000002", out_chan, out_data); else passed++;
    in_valid = 8'b0001_0000;
    #1;
    checks++; if (in_ready !== 8'h08) $display("FAIL lock_starve_ready: got %b want 00001000", in_ready); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL lock_starve_valid: got %b want 0", out_valid); else passed++;
    set_ch(3, 32'h3000_0003, 1'b1);
    in_valid = 8'b0001_1000;
    tick();
    checks++; if (out_chan !== 3'd3 || out_data !== 32'h3000_0003 || out_last !== 1'b1) $display("FAIL lock_beat3: got chan %0d data %h last %b want chan 3 data 30000003 last 1", out_chan, out_data, out_last); else passed++;
    checks++; if (in_ready !== 8'h10) $display("FAIL lock_release_ready: got %b want 00010000", in_ready); else passed++;
    tick();
    checks++; if (out_chan !== 3'd4 || out_data !== 32'h4444_0004) $display("FAIL lock_next_chan: got chan %0d data %h want chan 4 data 44440004", out_chan, out_data); else passed++;
    in_valid = 8'h00; mode = 1'b1;
    tick();
  endtask

  task automatic test_backpressure();
    mode = 1'b1; out_ready = 1'b1;
    set_ch(1, 32'h1111_0001, 1'b1);
    in_valid = 8'b0000_0010;
    tick();
    checks++; if (out_data !== 32'h1111_0001 || out_valid !== 1'b1) $display("FAIL bp_first: got data %h valid %b want 11110001 valid 1", out_data, out_valid); else passed++;
    out_ready = 1'b0;
    set_ch(1, 32'h1111_0002, 1'b1);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (in_ready !== 8'h00) $display("FAIL bp_ready[%0d]: got %b want 00000000", c, in_ready); else passed++;
      tick();
      checks++; if (out_data !== 32'h1111_0001 || out_valid !== 1'b1) $display("FAIL bp_hold[%0d]: got data %h valid %b want 11110001 valid 1", c, out_data, out_valid); else passed++;
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 8'h02) $display("FAIL bp_release_ready: got %b want 00000010", in_ready); else passed++;
    tick();
    checks++; if (out_data !== 32'h1111_0002 || out_valid !== 1'b1) $display("FAIL bp_next_beat: got data %h valid %b want 11110002 valid 1", out_data, out_valid); else passed++;
    in_valid = 8'h00;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup: got valid %b want 0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    mode = 1'b1; out_ready = 1'b1;
    set_ch(6, 32'h6666_0001, 1'b0);
    in_valid = 8'b0100_0000;
    tick();
    checks++; if (out_chan !== 3'd6 || out_last !== 1'b0 || out_valid !== 1'b1) $display("FAIL rmid_beat1: got chan %0d last %b valid %b want chan 6 last 0 valid 1", out_chan, out_last, out_valid); else passed++;
    reset = 1'b1;
    set_ch(2, 32'h2222_0002, 1'b1);
    in_valid = 8'b0000_0100;
    #1;
    checks++; if (in_ready !== 8'h00) $display("FAIL rmid_reset_ready: got %b want 00000000", in_ready); else passed++;
    tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL rmid_dropped: got valid %b want 0", out_valid); else passed++;
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 8'h04) $display("FAIL rmid_unlock_ready: got %b want 00000100", in_ready); else passed++;
    tick();
    checks++; if (out_chan !== 3'd2 || out_data !== 32'h2222_0002) $display("FAIL rmid_unlock_beat: got chan %0d data %h want chan 2 data 22220002", out_chan, out_data); else passed++;
    in_valid = 8'h00;
    tick();
  endtask

  initial begin
    checks = 0; passed = 0;
    reset = 1'b1; in_data = '0; in_valid = '0; in_last = '0;
    mode = 1'b0; sel = '0; out_ready = 1'b1;
    test_reset();
    test_sel();
    test_rr();
    test_lock();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
